// File: rtl/a429_pkg.sv
// a429_pkg: definitions shared by the ARINC429 bus-side blocks.
//   - FSM state encoding of the RX poller
//   - per-channel register offsets and the RX-ready status bit
//   - calc_aw(): index width needed to address n items
// No ports (package).
package a429_pkg;

    // Poller FSM encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_STAT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_PUSH = 3'd3;
    localparam logic [2:0] ST_NEXT = 3'd4;

    // Per-channel register map of the multi-channel controller
    localparam int STAT_OFS   = 1;
    localparam int RXD_OFS    = 2;
    localparam int RX_RDY_BIT = 0;

    // Smallest w with 2**w >= n
    function automatic int calc_aw(input int n);
        int w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/a429_wb_rx_poller_if.sv
// a429_wb_rx_poller_if: Wishbone bus between the RX poller (master) and the
// multi-channel ARINC429 controller slave port.
// Signal names are seen from the initiator side:
//   cyc_o, stb_o, adr_o[AW], wnr_o, dat_o[DW]  initiator -> slave
//   dat_i[DW], ack_i                            slave -> initiator
interface a429_wb_rx_poller_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          cyc_o;
    logic          stb_o;
    logic [AW-1:0] adr_o;
    logic          wnr_o;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i;
    logic          ack_i;

    modport master (
        output cyc_o, stb_o, adr_o, wnr_o, dat_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, adr_o, wnr_o, dat_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/a429_rr_next.sv
// a429_rr_next: combinational round-robin finder. Returns the first channel
// whose mask bit is set, searching upward from ptr_i (inclusive) and wrapping
// from N-1 to 0.
//   mask_i[N]   candidate channels
//   ptr_i[AW]   search start (must be < N)
//   next_o[AW]  selected channel (ptr_i when none_o=1)
//   none_o      no mask bit set
module a429_rr_next #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic [N-1:0]  mask_i,
    input  logic [AW-1:0] ptr_i,
    output logic [AW-1:0] next_o,
    output logic          none_o
);

    int            sum_s;
    logic [AW-1:0] idx_s;

    // Priority search: walk offsets high to low so the closest hit wins
    always_comb begin
        next_o = ptr_i;
        none_o = (mask_i == '0);
        sum_s  = 0;
        idx_s  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum_s  = int'(ptr_i) + i;
            idx_s  = (sum_s >= N) ? AW'(sum_s - N) : AW'(sum_s);
            next_o = mask_i[idx_s] ? idx_s : next_o;
        end
    end

endmodule

// File: rtl/a429_wb_rx_poller.sv
// a429_wb_rx_poller: Wishbone initiator that round-robin polls the RX status
// register of each enabled ARINC429 channel, reads any pending word and hands
// it out on a valid/ready stream tagged with its channel number.
// Ports:
//   clk_i, rst_i (synchronous, active-low), en_i, chan_mask_i[CHAN_NUM]
//   wb          Wishbone master modport (cyc/stb/adr/wnr/dat_o, dat_i/ack_i)
//   wrd_vld_o, wrd_rdy_i, wrd_dat_o[32], wrd_chan_o[CHAN_AW]  word stream
//   err_o       one-cycle pulse on bus timeout
//   busy_o      FSM not idle
// Optional build macro A429_POLL_IRQ_EN adds irq_i[CHAN_NUM]; only channels
// that are both enabled and interrupting are polled.
module a429_wb_rx_poller
    import a429_pkg::*;
#(
    parameter int CHAN_NUM = 8,
    parameter int CHAN_AW  = calc_aw(CHAN_NUM),
    parameter int REG_AW   = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [CHAN_NUM-1:0] chan_mask_i,
`ifdef A429_POLL_IRQ_EN
    input  logic [CHAN_NUM-1:0] irq_i,
`endif
    a429_wb_rx_poller_if.master wb,
    output logic                wrd_vld_o,
    input  logic                wrd_rdy_i,
    output logic [31:0]         wrd_dat_o,
    output logic [CHAN_AW-1:0]  wrd_chan_o,
    output logic                err_o,
    output logic                busy_o
);

    localparam int               AW       = CHAN_AW + REG_AW;
    localparam logic [REG_AW-1:0] STAT_A  = REG_AW'(STAT_OFS);
    localparam logic [REG_AW-1:0] RXD_A   = REG_AW'(RXD_OFS);
    // Last wait cycle before the timeout fires
    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]         state_q, state_d;
    logic [CHAN_AW-1:0] ptr_q, ptr_d;
    logic [7:0]         tmo_q, tmo_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic [AW-1:0]      adr_q, adr_d;
    logic               vld_q, vld_d;
    logic [31:0]        wdat_q, wdat_d;
    logic [CHAN_AW-1:0] wchan_q, wchan_d;
    logic               err_q, err_d;

    logic [CHAN_NUM-1:0] eff_mask_s;
    logic [CHAN_AW-1:0]  ptr_inc_s;
    logic [CHAN_AW-1:0]  start_s;
    logic [CHAN_AW-1:0]  next_s;
    logic                none_s;

`ifdef A429_POLL_IRQ_EN
    assign eff_mask_s = chan_mask_i & irq_i;
`else
    assign eff_mask_s = chan_mask_i;
`endif

    // IDLE resumes at the pointer itself; NEXT must move past the channel
    // just visited so each channel gets at most one word per round.
    assign ptr_inc_s = (ptr_q == CHAN_AW'(CHAN_NUM - 1)) ? '0 : ptr_q + CHAN_AW'(1);
    assign start_s   = (state_q == ST_NEXT) ? ptr_inc_s : ptr_q;

    a429_rr_next #(
        .N  (CHAN_NUM),
        .AW (CHAN_AW)
    ) u_rr_next (
        .mask_i (eff_mask_s),
        .ptr_i  (start_s),
        .next_o (next_s),
        .none_o (none_s)
    );

    // Next-state and output logic of the polling FSM
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tmo_d   = tmo_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        vld_d   = vld_q;
        wdat_d  = wdat_q;
        wchan_d = wchan_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_i && !none_s) begin
                    ptr_d   = next_s;
                    state_d = ST_STAT;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    adr_d   = {next_s, STAT_A};
                    tmo_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STAT: begin
                if (wb.ack_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    tmo_d   = 8'd0;
                    state_d = wb.dat_i[RX_RDY_BIT] ? ST_DATA : ST_NEXT;
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    tmo_d   = 8'd0;
                    err_d   = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DATA: begin
                // First DATA cycle is the mandatory idle bus cycle; launch here
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    adr_d = {ptr_q, RXD_A};
                    tmo_d = 8'd0;
                end else if (wb.ack_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    tmo_d   = 8'd0;
                    wdat_d  = wb.dat_i;
                    wchan_d = ptr_q;
                    vld_d   = 1'b1;
                    state_d = ST_PUSH;
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    tmo_d   = 8'd0;
                    err_d   = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_PUSH: begin
                if (wrd_rdy_i) begin
                    vld_d   = 1'b0;
                    state_d = ST_NEXT;
                end else begin
                    vld_d = 1'b1;
                end
            end
            ST_NEXT: begin
                if (!none_s) begin
                    ptr_d = next_s;
                end else begin
                    ptr_d = ptr_q;
                end
                if (en_i && !none_s) begin
                    state_d = ST_STAT;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    adr_d   = {next_s, STAT_A};
                    tmo_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any bus cycle and word
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            tmo_q   <= 8'd0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            adr_q   <= '0;
            vld_q   <= 1'b0;
            wdat_q  <= 32'd0;
            wchan_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            vld_q   <= vld_d;
            wdat_q  <= wdat_d;
            wchan_q <= wchan_d;
            err_q   <= err_d;
        end
    end

    assign wb.cyc_o   = cyc_q;
    assign wb.stb_o   = stb_q;
    assign wb.adr_o   = adr_q;
    assign wb.wnr_o   = 1'b0;
    assign wb.dat_o   = 32'd0;
    assign wrd_vld_o  = vld_q;
    assign wrd_dat_o  = wdat_q;
    assign wrd_chan_o = wchan_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_a429_wb_rx_poller.sv
// Self-checking bench for a429_wb_rx_poller: a behavioural controller slave
// with per-channel status/data registers and programmable ack latency, a
// table of single-word poll vectors, and hand sequences for timeout, stream
// stall, enable drop, mid-cycle reset, empty mask and (optionally) irq gating.
module tb_a429_wb_rx_poller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [7:0] mask;
    logic [7:0] irq;

    logic        vld;
    logic [31:0] wdat;
    logic [2:0]  wchan;
    logic        err;
    logic        busy;

    always #5 clk = ~clk;

    a429_wb_rx_poller_if #(.AW(5), .DW(32)) bus ();

    a429_wb_rx_poller dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .en_i        (en),
        .chan_mask_i (mask),
`ifdef A429_POLL_IRQ_EN
        .irq_i       (irq),
`endif
        .wb          (bus),
        .wrd_vld_o   (vld),
        .wrd_rdy_i   (rdy),
        .wrd_dat_o   (wdat),
        .wrd_chan_o  (wchan),
        .err_o       (err),
        .busy_o      (busy)
    );

    // Slave model state and observation logs
    logic        stat_m [8];
    logic [31:0] data_m [8];
    int          ack_delay;
    int          wcnt;
    logic        stb_prev;
    logic [2:0]  sch;
    logic [4:0]  adr_log [$];
    logic [34:0] wrd_log [$];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  mask;
        logic [2:0]  ch;
        logic [31:0] dat;
        int          dly;
        logic [4:0]  first_adr;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        rdy   = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        ack_delay = 0;
        for (int c = 0; c < 8; c++) begin
            stat_m[c] = 1'b0;
            data_m[c] = 32'd0;
        end
        adr_log.delete();
        wrd_log.delete();
    endtask

    task automatic go_idle();
        en = 1'b0;
        for (int i = 0; i < 60 && busy; i++) tick();
        check("idle", {63'd0, busy}, 64'd0);
    endtask

    // Wishbone slave: ack after ack_delay wait cycles; RXD read pops the word
    initial begin
        bus.ack_i = 1'b0;
        bus.dat_i = 32'hFFFF_FFFF;
        stb_prev  = 1'b0;
        wcnt      = 0;
        sch       = 3'd0;
        forever begin
            @(negedge clk);
            bus.ack_i = 1'b0;
            bus.dat_i = 32'hFFFF_FFFF;
            if (bus.cyc_o && bus.stb_o) begin
                if (!stb_prev) begin
                    adr_log.push_back(bus.adr_o);
                    wcnt = 0;
                end
                if (wcnt >= ack_delay) begin
                    bus.ack_i = 1'b1;
                    sch = bus.adr_o[4:2];
                    if (bus.adr_o[1:0] == 2'b01) begin
                        bus.dat_i = {31'd0, stat_m[sch]};
                    end else if (bus.adr_o[1:0] == 2'b10) begin
                        bus.dat_i    = data_m[sch];
                        stat_m[sch]  = 1'b0;
                    end else begin
                        bus.dat_i = 32'd0;
                    end
                end
                wcnt++;
            end
            stb_prev = bus.stb_o;
        end
    end

    // Stream monitor: log every completed transfer
    initial begin
        forever begin
            @(negedge clk);
            if (vld && rdy) wrd_log.push_back({wchan, wdat});
        end
    end

    initial begin
        vec_t       vec [6];
        logic [4:0] exp_a [4];
        logic [4:0] first;
        int         cnt;

        vec[0] = '{mask: 8'h05, ch: 3'd0, dat: 32'h1234_5678, dly: 0, first_adr: 5'h01};
        vec[1] = '{mask: 8'h80, ch: 3'd7, dat: 32'hDEAD_BEEF, dly: 1, first_adr: 5'h1D};
        vec[2] = '{mask: 8'h0C, ch: 3'd3, dat: 32'h0000_0001, dly: 2, first_adr: 5'h09};
        vec[3] = '{mask: 8'hFF, ch: 3'd5, dat: 32'hA5A5_0F0F, dly: 3, first_adr: 5'h01};
        vec[4] = '{mask: 8'h22, ch: 3'd5, dat: 32'h8000_0000, dly: 0, first_adr: 5'h05};
        vec[5] = '{mask: 8'h01, ch: 3'd0, dat: 32'hFFFF_FFFF, dly: 5, first_adr: 5'h01};

        irq  = 8'hFF;
        mask = 8'h00;
        do_reset();

        // Reset state
        check("reset_bus", {bus.cyc_o, bus.stb_o, bus.wnr_o, bus.adr_o, bus.dat_o}, 64'd0);
        check("reset_stream", {vld, err, busy, wchan, wdat}, 64'd0);

        // Table: one pending word per vector
        for (int v = 0; v < 6; v++) begin
            do_reset();
            mask            = vec[v].mask;
            ack_delay       = vec[v].dly;
            stat_m[vec[v].ch] = 1'b1;
            data_m[vec[v].ch] = vec[v].dat;
            en = 1'b1;
            for (int i = 0; i < 200 && wrd_log.size() == 0; i++) tick();
            go_idle();
            check("vec_words", 64'(wrd_log.size()), 64'd1);
            if (wrd_log.size() > 0) begin
                check("vec_dat", {32'd0, wrd_log[0][31:0]}, {32'd0, vec[v].dat});
                check("vec_chan", {61'd0, wrd_log[0][34:32]}, {61'd0, vec[v].ch});
            end
            first = (adr_log.size() > 0) ? adr_log[0] : 5'h1F;
            check("vec_first_adr", {59'd0, first}, {59'd0, vec[v].first_adr});
        end

        // Bus order STAT ch0, DATA ch0, STAT ch2, wrap to STAT ch0
        do_reset();
        mask = 8'h05;
        stat_m[0] = 1'b1;
        data_m[0] = 32'h1234_5678;
        en = 1'b1;
        exp_a[0] = 5'h01; exp_a[1] = 5'h02; exp_a[2] = 5'h09; exp_a[3] = 5'h01;
        for (int i = 0; i < 100 && adr_log.size() < 4; i++) tick();
        for (int k = 0; k < 4; k++) begin
            first = (adr_log.size() > k) ? adr_log[k] : 5'h1F;
            check("seq_adr", {59'd0, first}, {59'd0, exp_a[k]});
        end
        go_idle();
        check("seq_words", 64'(wrd_log.size()), 64'd1);
        if (wrd_log.size() > 0) check("seq_word", {29'd0, wrd_log[0]}, {29'd0, 3'd0, 32'h1234_5678});

        // Timeout: STAT on ch3 never acked
        do_reset();
        mask = 8'h08;
        ack_delay = 1000;
        en = 1'b1;
        for (int i = 0; i < 10 && !bus.cyc_o; i++) tick();
        cnt = 0;
        while (bus.cyc_o && cnt < 400) begin
            cnt++;
            tick();
        end
        check("tmo_cycles", 64'(cnt), 64'd255);
        check("tmo_err_hi", {62'd0, err, bus.cyc_o}, 64'd2);
        tick();
        check("tmo_err_lo", {57'd0, err, bus.cyc_o, bus.adr_o}, {57'd0, 1'b0, 1'b1, 5'h0D});
        check("tmo_words", 64'(wrd_log.size()), 64'd0);
        ack_delay = 0;
        go_idle();

        // Stream stall on ch1, then STAT ch2
        do_reset();
        mask = 8'h06;
        stat_m[1] = 1'b1;
        data_m[1] = 32'hCAFE_F00D;
        rdy = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 50 && !vld; i++) tick();
        check("stall_vld", {63'd0, vld}, 64'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_hold", {27'd0, vld, bus.cyc_o, wchan, wdat},
                  {27'd0, 1'b1, 1'b0, 3'd1, 32'hCAFE_F00D});
        end
        rdy = 1'b1;
        tick();
        check("stall_drop", {62'd0, vld, bus.cyc_o}, 64'd0);
        tick();
        check("stall_next", {58'd0, bus.cyc_o, bus.adr_o}, {58'd0, 1'b1, 5'h09});
        go_idle();
        check("stall_words", 64'(wrd_log.size()), 64'd1);

        // Enable dropped during a slow DATA access
        do_reset();
        mask = 8'h10;
        stat_m[4] = 1'b1;
        data_m[4] = 32'h0BAD_F00D;
        ack_delay = 3;
        en = 1'b1;
        for (int i = 0; i < 50 && !(bus.cyc_o && bus.adr_o == 5'h12); i++) tick();
        check("en_data_seen", {63'd0, bus.cyc_o}, 64'd1);
        en = 1'b0;
        for (int i = 0; i < 50 && wrd_log.size() == 0; i++) tick();
        for (int i = 0; i < 20 && busy; i++) tick();
        check("en_idle", {62'd0, busy, bus.cyc_o}, 64'd0);
        check("en_words", 64'(wrd_log.size()), 64'd1);
        if (wrd_log.size() > 0) check("en_word", {29'd0, wrd_log[0]}, {29'd0, 3'd4, 32'h0BAD_F00D});
        check("en_accesses", 64'(adr_log.size()), 64'd2);

        // Reset in the middle of a STAT on ch2
        do_reset();
        mask = 8'h04;
        ack_delay = 10;
        en = 1'b1;
        for (int i = 0; i < 10 && !bus.cyc_o; i++) tick();
        tick();
        tick();
        check("rst_pre_cyc", {63'd0, bus.cyc_o}, 64'd1);
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        check("rst_out", {54'd0, bus.cyc_o, bus.stb_o, vld, err, busy, bus.adr_o}, 64'd0);
        rst_n = 1'b1;
        ack_delay = 0;
        mask = 8'h05;
        adr_log.delete();
        en = 1'b1;
        for (int i = 0; i < 20 && adr_log.size() == 0; i++) tick();
        first = (adr_log.size() > 0) ? adr_log[0] : 5'h1F;
        check("rst_ptr", {59'd0, first}, {59'd0, 5'h01});
        go_idle();

        // Empty mask keeps the poller idle
        do_reset();
        mask = 8'h00;
        en   = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("zero_mask", {61'd0, busy, bus.cyc_o, err}, 64'd0);
        go_idle();

`ifdef A429_POLL_IRQ_EN
        // Only the interrupting channel is polled
        do_reset();
        mask = 8'hFF;
        irq  = 8'h40;
        en   = 1'b1;
        for (int i = 0; i < 30 && adr_log.size() < 2; i++) tick();
        for (int k = 0; k < 2; k++) begin
            first = (adr_log.size() > k) ? adr_log[k] : 5'h1F;
            check("irq_adr", {59'd0, first}, {59'd0, 5'h19});
        end
        go_idle();
        irq = 8'hFF;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
